// File: rtl/rshift_deser.sv
// rshift_deser: LSB-first serial-in, parallel-out deserializer.
// A one-entry holding register presents words on a ready/valid port.
module rshift_deser #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             clr,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             overrun,
    output logic [CW-1:0]    bit_cnt
);

    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hold;
    logic             r_valid;
    logic             r_ovr;

    logic             w_full;
    logic             w_xfer;
    logic             w_consume;
    logic [WIDTH-1:0] w_shift;

    assign w_full    = (r_cnt == CW'(WIDTH));
    // The holding register is free when empty or being drained this edge.
    assign w_xfer    = !clr && w_full && (!r_valid || par_ready);
    assign w_consume = r_valid && par_ready;
    assign w_shift   = {sin, r_sr[WIDTH-1:1]};

    // Shift register, bit counter and sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
            r_ovr <= 1'b0;
        end else if (clr) begin
            r_sr  <= '0;
            r_cnt <= '0;
            r_ovr <= 1'b0;
        end else if (w_xfer) begin
            // The emptied register takes this cycle's bit, so no bubble.
            if (sin_en) begin
                r_sr  <= w_shift;
                r_cnt <= CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end else if (w_full) begin
            if (sin_en) begin
                r_ovr <= 1'b1;
            end
        end else if (sin_en) begin
            r_sr  <= w_shift;
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Holding register and valid flag; a consume and a reload may coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold  <= '0;
            r_valid <= 1'b0;
        end else if (w_xfer) begin
            r_hold  <= r_sr;
            r_valid <= 1'b1;
        end else if (w_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign par_out   = r_hold;
    assign par_valid = r_valid;
    assign overrun   = r_ovr;
    assign bit_cnt   = r_cnt;

endmodule

// File: tb/tb_rshift_deser.sv
// tb_rshift_deser: directed and random checks of rshift_deser
// against a queue-based model of the received bit stream.
module tb_rshift_deser;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          sin;
    logic          sin_en;
    logic          clr;
    logic          par_ready;
    logic [W-1:0]  par_out;
    logic          par_valid;
    logic          overrun;
    logic [CW-1:0] bit_cnt;

    int checks   = 0;
    int failures = 0;

    bit            mq[$];
    logic [W-1:0]  mhold;
    bit            mvalid;
    bit            movr;

    rshift_deser #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_en    (sin_en),
        .clr       (clr),
        .par_out   (par_out),
        .par_valid (par_valid),
        .par_ready (par_ready),
        .overrun   (overrun),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mhold  = '0;
        mvalid = 1'b0;
        movr   = 1'b0;
    endtask

    // Next state of the model for one clock edge with the given inputs.
    task automatic model_step(input bit s, input bit e, input bit c,
                              input bit r);
        bit hs;
        bit full;
        hs   = mvalid && r;
        full = (mq.size() == W);
        if (c) begin
            mq.delete();
            movr = 1'b0;
            if (hs) mvalid = 1'b0;
        end else if (full && (!mvalid || r)) begin
            for (int i = 0; i < W; i++) mhold[i] = mq[i];
            mvalid = 1'b1;
            mq.delete();
            if (e) mq.push_back(s);
        end else begin
            if (hs) mvalid = 1'b0;
            if (e) begin
                if (full) movr = 1'b1;
                else mq.push_back(s);
            end
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, ".out"}, 32'(par_out), 32'(mhold));
        chk({tag, ".vld"}, 32'(par_valid), 32'(mvalid));
        chk({tag, ".ovr"}, 32'(overrun), 32'(movr));
        chk({tag, ".cnt"}, 32'(bit_cnt), 32'(mq.size()));
    endtask

    // Called at a negedge: drive, advance model, check at next negedge.
    task automatic cyc(input bit s, input bit e, input bit c, input bit r,
                       input string tag);
        sin       = s;
        sin_en    = e;
        clr       = c;
        par_ready = r;
        model_step(s, e, c, r);
        @(negedge clk);
        compare(tag);
    endtask

    task automatic send(input logic [W-1:0] w, input bit r,
                        input string tag);
        for (int i = 0; i < W; i++) cyc(w[i], 1'b1, 1'b0, r, tag);
    endtask

    task automatic flush();
        cyc(1'b0, 1'b0, 1'b1, 1'b1, "flush");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "flush");
    endtask

    initial begin
        logic [15:0] two;
        rst = 1'b1; sin = 1'b0; sin_en = 1'b0; clr = 1'b0; par_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare("reset");
        rst = 1'b0;

        // Single word, one-cycle valid pulse one edge after the 8th bit.
        send(8'hA5, 1'b1, "t1");
        chk("t1.pre", 32'(par_valid), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "t1");
        chk("t1.word", 32'(par_out), 32'hA5);
        chk("t1.vld1", 32'(par_valid), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "t1");
        chk("t1.vld0", 32'(par_valid), 32'd0);
        chk("t1.ovr", 32'(overrun), 32'd0);

        // Back-to-back streaming.
        two = 16'hF03C;
        for (int i = 0; i < 16; i++) begin
            cyc(two[i], 1'b1, 1'b0, 1'b1, "t2");
            if (i == 8) begin
                chk("t2.w0", 32'(par_out), 32'h3C);
                chk("t2.cnt1", 32'(bit_cnt), 32'd1);
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "t2");
        chk("t2.w1", 32'(par_out), 32'hF0);
        chk("t2.cnt0", 32'(bit_cnt), 32'd1 - 32'd1);
        flush();

        // Back-pressure and overrun.
        send(8'h81, 1'b0, "t3");
        send(8'h7E, 1'b0, "t3");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "t3");
        chk("t3.hold", 32'(par_out), 32'h81);
        chk("t3.cnt8", 32'(bit_cnt), 32'd8);
        chk("t3.ovr", 32'(overrun), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "t3");
        chk("t3.next", 32'(par_out), 32'h7E);
        chk("t3.vld", 32'(par_valid), 32'd1);
        flush();

        // Transfer collides with consume and a new bit.
        send(8'h11, 1'b1, "t4");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "t4");
        send(8'h22, 1'b0, "t4");
        chk("t4.hold", 32'(par_out), 32'h11);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, "t4");
        chk("t4.out", 32'(par_out), 32'h22);
        chk("t4.vld", 32'(par_valid), 32'd1);
        chk("t4.cnt", 32'(bit_cnt), 32'd1);
        flush();

        // clr mid-word.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, "t5");
        cyc(1'b1, 1'b1, 1'b1, 1'b1, "t5");
        chk("t5.cnt", 32'(bit_cnt), 32'd0);
        chk("t5.ovr", 32'(overrun), 32'd0);
        send(8'h55, 1'b1, "t5");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "t5");
        chk("t5.word", 32'(par_out), 32'h55);
        flush();

        // Async reset with valid=1, cnt=3, overrun=1.
        send(8'hFF, 1'b0, "t6");
        send(8'h0F, 1'b0, "t6");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "t6");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, "t6");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "t6");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "t6");
        chk("t6.cnt3", 32'(bit_cnt), 32'd3);
        chk("t6.pvld", 32'(par_valid), 32'd1);
        chk("t6.povr", 32'(overrun), 32'd1);
        sin_en = 1'b0; par_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6.rout", 32'(par_out), 32'd0);
        chk("t6.rvld", 32'(par_valid), 32'd0);
        chk("t6.rovr", 32'(overrun), 32'd0);
        chk("t6.rcnt", 32'(bit_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        compare("t6.rst");
        send(8'hC3, 1'b1, "t6");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "t6");
        chk("t6.word", 32'(par_out), 32'hC3);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            cyc(1'($urandom), $urandom_range(0, 9) < 8,
                $urandom_range(0, 49) == 0, 1'($urandom), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
